// File: rtl/rf_frame_tx_if.sv
// Byte-in / framed-bit-out bundle between the UART receiver, rf_frame_tx and the RF XOR stage.
// master drives received bytes and observes the symbol stream; slave is the framer.
interface rf_frame_tx_if;
    logic [7:0] rx_dat;
    logic       rx_stb;
    logic       rx_err;
    logic       mod_bit;
    logic       sym_stb;
    logic       busy;
    logic       fifo_full;
    logic       ovf;

    modport master (
        output rx_dat, rx_stb, rx_err,
        input  mod_bit, sym_stb, busy, fifo_full, ovf
    );

    modport slave (
        input  rx_dat, rx_stb, rx_err,
        output mod_bit, sym_stb, busy, fifo_full, ovf
    );
endinterface

// File: rtl/rf_frame_tx.sv
// Buffers received bytes in a small FIFO and streams them as preamble + sync + MSB-first
// payload frames, one bit per symbol period, for the RF carrier modulator.
module rf_frame_tx #(
    parameter int unsigned SCW     = 12,
    parameter int unsigned sym_cnt = 3333,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PRE_LEN = 16,
    parameter logic [7:0]  SYNC    = 8'h2D
) (
    input logic           clk,
    input logic           rst_n,
    rf_frame_tx_if.slave  bus_io
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned IMAX = (PRE_LEN > 8) ? PRE_LEN : 8;
    localparam int unsigned IW   = $clog2(IMAX);

    typedef enum logic [1:0] {StIdle, StPre, StSync, StData} state_e;

    logic [7:0]     mem_q [DEPTH];
    logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           full_q, ovf_q;

    state_e         state_q;
    logic [SCW-1:0] sym_q;
    logic [IW-1:0]  idx_q;
    logic [7:0]     sh_q;
    logic           mod_bit_q, sym_stb_q, busy_q;

    logic           sym_end, last8, empty, pop, push;
    logic [7:0]     head;

    always_comb begin
        sym_end = busy_q && (sym_q == SCW'(sym_cnt - 1));
        last8   = (idx_q == IW'(7));
        empty   = (count_q == '0);
        // Sync end always pops (frame guaranteed non-empty); data end pops only if more queued.
        pop     = sym_end && last8 &&
                  ((state_q == StSync) || ((state_q == StData) && !empty));
        push    = bus_io.rx_stb && !bus_io.rx_err && (!full_q || pop);
        count_d = count_q + CW'(push) - CW'(pop);
        head    = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus_io.rx_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            ovf_q   <= bus_io.rx_stb && !bus_io.rx_err && full_q && !pop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sym_q     <= '0;
            idx_q     <= '0;
            sh_q      <= '0;
            mod_bit_q <= 1'b0;
            sym_stb_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sym_stb_q <= 1'b0;
            if (busy_q) sym_q <= sym_end ? '0 : sym_q + SCW'(1);
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        state_q   <= StPre;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        mod_bit_q <= 1'b1;
                        sym_stb_q <= 1'b1;
                    end
                end
                StPre: begin
                    if (sym_end) begin
                        sym_stb_q <= 1'b1;
                        if (idx_q == IW'(PRE_LEN - 1)) begin
                            state_q   <= StSync;
                            idx_q     <= '0;
                            sh_q      <= SYNC;
                            mod_bit_q <= SYNC[7];
                        end else begin
                            idx_q     <= idx_q + IW'(1);
                            // Next symbol is odd-indexed when current one is even.
                            mod_bit_q <= idx_q[0];
                        end
                    end
                end
                StSync, StData: begin
                    if (sym_end) begin
                        if (!last8) begin
                            sym_stb_q <= 1'b1;
                            idx_q     <= idx_q + IW'(1);
                            sh_q      <= sh_q << 1;
                            mod_bit_q <= sh_q[6];
                        end else if (pop) begin
                            sym_stb_q <= 1'b1;
                            state_q   <= StData;
                            idx_q     <= '0;
                            sh_q      <= head;
                            mod_bit_q <= head[7];
                        end else begin
                            state_q   <= StIdle;
                            idx_q     <= '0;
                            busy_q    <= 1'b0;
                            mod_bit_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.mod_bit   = mod_bit_q;
    assign bus_io.sym_stb   = sym_stb_q;
    assign bus_io.busy      = busy_q;
    assign bus_io.fifo_full = full_q;
    assign bus_io.ovf       = ovf_q;

endmodule

// File: tb/tb_rf_frame_tx.sv
// Self-checking bench for rf_frame_tx: table-driven frames plus hand-written corner sequences,
// with a per-symbol scoreboard of expected mod_bit values.
module tb_rf_frame_tx;

    localparam int SYM = 4;
    localparam int PRE = 4;
    localparam int DEP = 4;
    localparam logic [7:0] SYNC_B = 8'h2D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rf_frame_tx_if bus ();

    rf_frame_tx #(
        .SCW    (3),
        .sym_cnt(SYM),
        .DEPTH  (DEP),
        .PRE_LEN(PRE),
        .SYNC   (SYNC_B)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  n;
        logic [47:0] b;
        logic        err;
        logic [1:0]  sp;
        logic [2:0]  n_exp;
        logic [47:0] e;
        logic [9:0]  busy_exp;
        logic [1:0]  ovf_exp;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic exp_q[$];
    int   n_frames = 0, n_rise = 0, n_sym = 0, n_ovf = 0;
    int   busy_run = 0, busy_len = 0, rise_cyc = 0, last_stb = 0;
    logic busy_prev = 1'b0, mod_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input int n, input logic [47:0] b, input logic err, input int sp,
                                input int n_exp, input logic [47:0] e, input int busy_exp,
                                input int ovf_exp);
        vec_t v;
        v.n = 3'(n);
        v.b = b;
        v.err = err;
        v.sp = 2'(sp);
        v.n_exp = 3'(n_exp);
        v.e = e;
        v.busy_exp = 10'(busy_exp);
        v.ovf_exp = 2'(ovf_exp);
        return v;
    endfunction

    task automatic push_frame(input logic [47:0] b, input int n);
        logic [7:0] s;
        logic [7:0] by;
        s = SYNC_B;
        for (int i = 0; i < PRE; i++) exp_q.push_back((i % 2) == 0);
        for (int i = 7; i >= 0; i--) exp_q.push_back(s[i]);
        for (int k = 0; k < n; k++) begin
            by = b[8*k +: 8];
            for (int i = 7; i >= 0; i--) exp_q.push_back(by[i]);
        end
    endtask

    task automatic clear_counts();
        n_frames = 0;
        n_rise = 0;
        n_sym = 0;
        n_ovf = 0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 4000 && n_frames == 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("frame_end_seen", int'(n_frames > 0), 1);
    endtask

    task automatic drive(input logic [7:0] d);
        bus.rx_dat = d;
        bus.rx_stb = 1'b1;
        bus.rx_err = 1'b0;
    endtask

    task automatic release_in();
        bus.rx_stb = 1'b0;
        bus.rx_err = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int t0;
        int last_t;
        int k;
        t0 = 0;
        clear_counts();
        if (v.n_exp != 0) push_frame(v.e, int'(v.n_exp));
        last_t = (int'(v.n) - 1) * int'(v.sp);
        for (int t = 0; t <= last_t; t++) begin
            @(posedge clk);
            #1;
            if (t == 0) t0 = cyc;
            if ((t % int'(v.sp)) == 0) begin
                k = t / int'(v.sp);
                chk($sformatf("fifo_full_before_write_%0d", k), bus.fifo_full,
                    int'(!v.err && k >= DEP));
                chk($sformatf("ovf_before_write_%0d", k), bus.ovf,
                    int'(!v.err && v.sp == 2'd1 && k >= DEP + 1));
                bus.rx_dat = v.b[8*k +: 8];
                bus.rx_stb = 1'b1;
                bus.rx_err = v.err;
            end else begin
                release_in();
            end
        end
        @(posedge clk);
        #1;
        release_in();
        if (v.n_exp == 0) begin
            repeat (20) @(posedge clk);
            #1;
            chk("err_no_frame", n_rise, 0);
            chk("err_no_ovf", n_ovf, 0);
            chk("err_fifo_full", bus.fifo_full, 0);
        end else begin
            wait_frame();
            chk("busy_length", busy_len, int'(v.busy_exp));
            chk("start_latency", rise_cyc - t0, 2);
            chk("symbol_count", n_sym, int'(v.busy_exp) / SYM);
            chk("ovf_count", n_ovf, int'(v.ovf_exp));
            chk("frame_count", n_frames, 1);
            chk("pending_symbols", exp_q.size(), 0);
        end
        exp_q.delete();
        repeat (3) @(posedge clk);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle monitor: frame timing, idle invariants, and symbol scoreboard.
    initial forever begin
        logic e;
        @(negedge clk);
        if (bus.busy) begin
            if (!busy_prev) begin
                rise_cyc = cyc;
                n_rise++;
            end
            busy_run++;
        end else begin
            if (busy_prev) begin
                busy_len = busy_run;
                n_frames++;
            end
            busy_run = 0;
            chk("idle_mod_bit", bus.mod_bit, 0);
            chk("idle_sym_stb", bus.sym_stb, 0);
        end
        if (bus.busy && bus.mod_bit !== mod_prev) chk("mod_bit_change_off_strobe", bus.sym_stb, 1);
        if (bus.sym_stb) begin
            if (bus.busy && busy_prev) chk("sym_stb_spacing", cyc - last_stb, SYM);
            last_stb = cyc;
            n_sym++;
            if (exp_q.size() == 0) begin
                chk("unexpected_symbol", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("symbol_bit_%0d", n_sym - 1), bus.mod_bit, e);
            end
        end
        if (bus.ovf) n_ovf++;
        busy_prev = bus.busy;
        mod_prev = bus.mod_bit;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[4];
        int n;

        bus.rx_dat = '0;
        bus.rx_stb = 1'b0;
        bus.rx_err = 1'b0;

        vt[0] = mk(1, 48'hA5, 1'b0, 1, 1, 48'hA5, 80, 0);
        vt[1] = mk(2, 48'hFF01, 1'b0, 3, 2, 48'hFF01, 112, 0);
        vt[2] = mk(6, 48'h665544332211, 1'b0, 1, 4, 48'h44332211, 176, 2);
        vt[3] = mk(1, 48'h77, 1'b1, 1, 0, 48'h0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_mod_bit", bus.mod_bit, 0);
        chk("reset_sym_stb", bus.sym_stb, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_fifo_full", bus.fifo_full, 0);
        chk("reset_ovf", bus.ovf, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 4; i++) run_vec(vt[i]);

        // Full FIFO with a write landing on the same cycle as a data-end pop.
        clear_counts();
        push_frame(48'hF6E5D4C3B2A1, 6);
        @(posedge clk);
        #1;
        n = cyc;
        drive(8'hA1);
        wait_to(n + 1);
        drive(8'hB2);
        wait_to(n + 2);
        drive(8'hC3);
        wait_to(n + 3);
        drive(8'hD4);
        wait_to(n + 4);
        release_in();
        chk("full_after_four", bus.fifo_full, 1);
        wait_to(n + 60);
        chk("full_after_sync_pop", bus.fifo_full, 0);
        drive(8'hE5);
        wait_to(n + 61);
        release_in();
        chk("full_refilled", bus.fifo_full, 1);
        wait_to(n + 81);
        chk("full_before_pop_write", bus.fifo_full, 1);
        drive(8'hF6);
        wait_to(n + 82);
        release_in();
        chk("ovf_on_pop_write", bus.ovf, 0);
        chk("full_on_pop_write", bus.fifo_full, 1);
        wait_frame();
        chk("pop_write_busy_length", busy_len, 240);
        chk("pop_write_ovf_count", n_ovf, 0);
        chk("pop_write_pending", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);

        // Asynchronous reset in the middle of the first payload byte.
        clear_counts();
        push_frame(48'h81FF, 2);
        @(posedge clk);
        #1;
        n = cyc;
        drive(8'hFF);
        wait_to(n + 1);
        drive(8'h81);
        wait_to(n + 2);
        release_in();
        wait_to(n + 54);
        chk("pre_reset_busy", bus.busy, 1);
        chk("pre_reset_mod_bit", bus.mod_bit, 1);
        chk("pre_reset_sym_stb", bus.sym_stb, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", bus.busy, 0);
        chk("async_reset_mod_bit", bus.mod_bit, 0);
        chk("async_reset_sym_stb", bus.sym_stb, 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b1;
        clear_counts();
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_no_frame", n_rise, 0);
        chk("post_reset_fifo_full", bus.fifo_full, 0);
        run_vec(mk(1, 48'h5A, 1'b0, 1, 1, 48'h5A, 80, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_frame_tx.md
# rf_frame_tx

- Downstream of the UART receiver (`acia_rx`); upstream of the RF XOR stage.
- Accepts received bytes (`rx_dat`/`rx_stb`/`rx_err`) into a small FIFO and builds a framed bit stream for the carrier modulator: preamble, then sync byte, then payload bytes MSB-first, one bit per symbol period.
- `mod_bit` feeds the XOR against the NCO carrier bit to produce `rf`.
- Paced by an internal symbol-rate counter, so a frame keeps streaming while new bytes arrive.

## Interface
- `SCW`, 12, symbol counter width; must satisfy 2^SCW ≥ `sym_cnt`.
- `sym_cnt`, 3333, clock cycles per symbol (4 MHz / 1200); must be ≥ 2.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `PRE_LEN`, 16, preamble length in symbols; even, ≥ 2.
- `SYNC`, 8'h2D, sync byte sent after the preamble.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_dat`  in  8  received byte; valid when `rx_stb` = 1.
- `rx_stb`  in  1  one-cycle byte-valid strobe.
- `rx_err`  in  1  framing error; qualifies `rx_stb` in the same cycle.
- `mod_bit`  out  1  current symbol bit; 0 when idle.
- `sym_stb`  out  1  one-cycle pulse on the first cycle of each transmitted symbol.
- `busy`  out  1  frame in progress.
- `fifo_full`  out  1  FIFO holds `DEPTH` entries.
- `ovf`  out  1  one-cycle pulse when a byte is dropped because the FIFO is full.

## Operation
- Reset: FIFO emptied, FSM in IDLE, symbol counter 0. All outputs 0.
- FIFO write: occurs when `rx_stb` & !`rx_err` & (!`fifo_full` | pop this cycle).
  - `rx_stb` & `rx_err`: byte discarded silently, no `ovf`.
  - `rx_stb` & !`rx_err` & full & no pop: byte discarded, `ovf` pulses next cycle.
- Symbol counter: runs 0..`sym_cnt`-1 while `busy`, wraps to 0; held at 0 in IDLE. A symbol ends when the count is `sym_cnt`-1.
- FSM:
  - IDLE: `mod_bit` = 0. If FIFO non-empty, go to PREAMBLE next cycle.
  - PREAMBLE: `PRE_LEN` symbols alternating 1,0,1,0…, starting with 1. Then go to SYNC.
  - SYNC: 8 symbols, `SYNC` MSB-first. At the last SYNC symbol end, pop the FIFO head into the shift register and go to DATA.
  - DATA: 8 symbols, MSB-first. At the 8th symbol end:
    - FIFO non-empty: pop the next byte and continue DATA with no gap and no new preamble.
    - FIFO empty: go to IDLE.
- A frame always carries at least one payload byte. The FIFO is non-empty on entering PREAMBLE, and no pop happens before SYNC ends.
- `busy` = 1 in PREAMBLE, SYNC and DATA.
- `fifo_full` is registered from the FIFO count.

## Timing
- `rx_stb` in cycle n, FIFO empty, IDLE:
  - entry visible in cycle n+1;
  - PREAMBLE entered in cycle n+2, with `busy` = 1, `mod_bit` = 1, `sym_stb` = 1.
- Every symbol lasts exactly `sym_cnt` cycles. `mod_bit` changes only in a cycle where `sym_stb` = 1.
- Frame with N bytes: `busy` high for exactly (`PRE_LEN` + 8 + 8N) × `sym_cnt` cycles.
- Frame end: `busy` and `mod_bit` return to 0 in the cycle after the last symbol's final cycle.
- Pop and write in the same cycle: both occur and the count is unchanged, including when full.
- A byte arriving after the IDLE decision but within the last DATA symbol is still appended to the current frame only if the FIFO is non-empty at the 8th-symbol end.
- `ovf`: registered, one cycle, in cycle n+1 for a drop in cycle n.
- Reset asserted mid-frame: all outputs 0 immediately (asynchronous). FIFO contents lost. After release, the FSM starts in IDLE.

## Test plan
- `sym_cnt`=4, `PRE_LEN`=4, one strobe with 0xA5:
  - `mod_bit` per symbol = 1,0,1,0, 0,0,1,0,1,1,0,1, 1,0,1,0,0,1,0,1;
  - `busy` high for 80 cycles;
  - 20 `sym_stb` pulses spaced 4 cycles apart.
- Two strobes (0x01, then 0xFF) 3 cycles apart: a single frame of 4+8+16 symbols, payload bits 00000001 11111111, no gap between the bytes.
- `DEPTH`=4, 6 back-to-back strobes during the preamble:
  - `fifo_full` asserts after the 4th write;
  - two `ovf` pulses;
  - frame carries exactly the first 4 bytes.
- Strobe with `rx_err`=1: no write, no `ovf`, `busy` stays 0.
- FIFO full, strobe in the same cycle as a DATA pop: byte accepted, `fifo_full` stays 1, no `ovf`; the byte is transmitted later.
- `rst_n` low for 1 cycle mid-DATA:
  - `mod_bit`, `busy`, `sym_stb` go to 0 without waiting for a clock edge;
  - FIFO empty;
  - a new strobe after release starts a fresh frame with the preamble.
